// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial W-bit subtractor, diff = a - b (mod 2^W), LSB
//               first. One full-subtractor cell and a borrow flip-flop are
//               reused over W cycles. Optional signed-overflow output is
//               enabled by defining SERIAL_SUB_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]  a_sr;
  logic [W-1:0]  b_sr;
  logic [W-2:0]  diff_sr;    // upper result bits collected so far
  logic [W-1:0]  diff_nxt;   // result word after this cycle's bit is inserted
  logic [CW-1:0] count;
  logic          bin;
  logic          ai, bi, d, bout;
  logic          accept;
  logic          last;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  // Full-subtractor cell on the current operand LSBs
  always_comb begin
    ai       = a_sr[0];
    bi       = b_sr[0];
    d        = ai ^ bi ^ bin;
    bout     = (~ai & bi) | (~(ai ^ bi) & bin);
    diff_nxt = {d, diff_sr};
    last     = (count == LAST);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state, status outputs and start acceptance
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shift registers, borrow FF, bit counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      count   <= '0;
      bin     <= 1'b0;
      diff    <= '0;
      borrow  <= 1'b0;
    end else if (accept) begin
      a_sr    <= a;
      b_sr    <= b;
      count   <= '0;
      bin     <= 1'b0;
      diff    <= '0;
      borrow  <= 1'b0;
    end else if (busy) begin
      a_sr    <= {1'b0, a_sr[W-1:1]};
      b_sr    <= {1'b0, b_sr[W-1:1]};
      diff_sr <= diff_nxt[W-1:1];
      bin     <= bout;
      count   <= count + CW'(1);
      if (last) begin
        diff   <= diff_nxt;
        borrow <= bout;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Signed overflow from captured operand MSBs and the final result MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_msb <= a[W-1];
      b_msb <= b[W-1];
      ovf   <= 1'b0;
    end else if (busy && last) begin
      ovf   <= (a_msb ^ b_msb) & (a_msb ^ d);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor at W=8 and W=13.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, start13;
  logic [7:0]  a8, b8, diff8;
  logic [12:0] a13, b13, diff13;
  logic        busy8, done8, borrow8;
  logic        busy13, done13, borrow13;
`ifdef SERIAL_SUB_OVF_EN
  logic        ovf8, ovf13;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_subtractor #(.W(13)) dut13 (
    .clk(clk), .rst_n(rst_n), .start(start13), .a(a13), .b(b13),
    .busy(busy13), .done(done13), .diff(diff13), .borrow(borrow13)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf13)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       br;
    logic       ov;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain modular / signed arithmetic on w-bit operands
  function automatic void model(input int w, input int ua, input int ub,
                                output int ed, output logic eb, output logic eo);
    int sa, sb, r;
    ed = (ua - ub) & ((1 << w) - 1);
    eb = (ua < ub);
    sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    r  = sa - sb;
    eo = (r > (1 << (w - 1)) - 1) || (r < -(1 << (w - 1)));
  endfunction

  // One full W=8 operation: busy window, done pulse, result, then hold
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic [7:0] ed,
                     input logic eb, input logic eo, input string nm);
    int bad;
    @(negedge clk);
    start8 = 1'b1; a8 = ta; b8 = tb_v;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy8 !== 1'b1 || done8 !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    chk({nm, "_busy"}, 32'(bad), 32'd0);
    chk({nm, "_done"}, {30'd0, busy8, done8}, 32'd1);
    chk({nm, "_diff"}, {24'd0, diff8}, {24'd0, ed});
    chk({nm, "_borrow"}, {31'd0, borrow8}, {31'd0, eb});
`ifdef SERIAL_SUB_OVF_EN
    chk({nm, "_ovf"}, {31'd0, ovf8}, {31'd0, eo});
`else
    if (eo === 1'bx) $display("note: unknown ovf expectation for %s", nm);
`endif
    @(posedge clk); #1;
    chk({nm, "_pulse"}, {30'd0, busy8, done8}, 32'd0);
    chk({nm, "_hold"}, {24'd0, diff8}, {24'd0, ed});
  endtask

  // One full W=13 operation checked against the model
  task automatic op13(input logic [12:0] ta, input logic [12:0] tb_v, input string nm);
    int bad, ed;
    logic eb, eo;
    model(13, int'(ta), int'(tb_v), ed, eb, eo);
    @(negedge clk);
    start13 = 1'b1; a13 = ta; b13 = tb_v;
    @(posedge clk); #1;
    start13 = 1'b0;
    a13 = 13'($urandom); b13 = 13'($urandom);
    bad = 0;
    for (int i = 0; i < 13; i++) begin
      if (busy13 !== 1'b1 || done13 !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    chk({nm, "_busy"}, 32'(bad), 32'd0);
    chk({nm, "_done"}, {30'd0, busy13, done13}, 32'd1);
    chk({nm, "_diff"}, {19'd0, diff13}, 32'(ed));
    chk({nm, "_borrow"}, {31'd0, borrow13}, {31'd0, eb});
`ifdef SERIAL_SUB_OVF_EN
    chk({nm, "_ovf"}, {31'd0, ovf13}, {31'd0, eo});
`else
    if (eo === 1'bx) $display("note: unknown ovf expectation for %s", nm);
`endif
  endtask

  initial begin
    int bad, ed;
    logic eb, eo;
    logic [7:0] ra, rb;

    vecs[0] = '{a: 8'h3C, b: 8'h15, d: 8'h27, br: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 8'h05, b: 8'h0A, d: 8'hFB, br: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 8'hA5, b: 8'hA5, d: 8'h00, br: 1'b0, ov: 1'b0};
    vecs[3] = '{a: 8'h80, b: 8'h01, d: 8'h7F, br: 1'b0, ov: 1'b1};
    vecs[4] = '{a: 8'h10, b: 8'h01, d: 8'h0F, br: 1'b0, ov: 1'b0};
    vecs[5] = '{a: 8'h00, b: 8'hFF, d: 8'h01, br: 1'b1, ov: 1'b0};
    vecs[6] = '{a: 8'h7F, b: 8'hFF, d: 8'h80, br: 1'b1, ov: 1'b1};
    vecs[7] = '{a: 8'hFF, b: 8'h00, d: 8'hFF, br: 1'b0, ov: 1'b0};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    start13 = 1'b0; a13 = 13'h0; b13 = 13'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state8", {28'd0, busy8, done8, borrow8, |diff8}, 32'd0);
    chk("reset_state13", {28'd0, busy13, done13, borrow13, |diff13}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 8; i++)
      op8(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br, vecs[i].ov, $sformatf("vec%0d", i));

    // start held high with new operands during RUN; back-to-back at done
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h3C; b8 = 8'h15;
    @(posedge clk); #1;
    a8 = 8'h05; b8 = 8'h0A;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy8 !== 1'b1 || done8 !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    chk("b2b_first_busy", 32'(bad), 32'd0);
    chk("b2b_first_done", {30'd0, busy8, done8}, 32'd1);
    chk("b2b_first_diff", {24'd0, diff8}, 32'h27);
    chk("b2b_first_borrow", {31'd0, borrow8}, 32'd0);
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("b2b_restart", {30'd0, busy8, done8}, 32'd2);
    chk("b2b_cleared", {23'd0, diff8, borrow8}, 32'd0);
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (busy8 !== 1'b1 || done8 !== 1'b0) bad++;
    end
    chk("b2b_second_busy", 32'(bad), 32'd0);
    @(posedge clk); #1;
    chk("b2b_second_done", {30'd0, busy8, done8}, 32'd1);
    chk("b2b_second_diff", {24'd0, diff8}, 32'hFB);
    chk("b2b_second_borrow", {31'd0, borrow8}, 32'd1);

    // Asynchronous reset during RUN cycle 4
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h3C; b8 = 8'h15;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_busy", {31'd0, busy8}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {28'd0, busy8, done8, borrow8, |diff8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op8(8'h3C, 8'h15, 8'h27, 1'b0, 1'b0, "after_reset");

    // Random operations, W=8
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = (n % 16 == 0) ? ra : 8'($urandom);
      model(8, int'(ra), int'(rb), ed, eb, eo);
      op8(ra, rb, 8'(ed), eb, eo, $sformatf("rnd8_%0d", n));
    end

    // Random operations, W=13 (plus boundary operands)
    op13(13'h0000, 13'h1FFF, "w13_zero_minus_max");
    op13(13'h1000, 13'h0001, "w13_minneg_minus_one");
    for (int n = 0; n < 1000; n++)
      op13(13'($urandom), 13'($urandom), $sformatf("rnd13_%0d", n));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
